mdu_iter: RTL and testbench

Iterative RV32M multiply/divide unit in the execute stage. Its registered result feeds the ALU-output path into the DWB (data memory / writeback) stage. It accepts one operation per start pulse and runs a shift-add multiply or restoring divide, one bit per cycle. The pipeline is held via `busy` and resumes when the unit pulses `done`.

---
 rtl/mdu_pkg.sv | 34 +++
 rtl/mdu_negate.sv | 12 +
 rtl/mdu_iter.sv | 204 ++++++++++++++++++++
 tb/tb_mdu_iter.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared types and constants for the iterative RV32M multiply/divide unit.
package mdu_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } mdu_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } mdu_state_t;

  localparam logic [31:0] DIV0_Q = 32'hFFFF_FFFF;
  localparam logic [31:0] OVF_Q  = 32'h8000_0000;

  // MUL only uses the low product half, which is sign-agnostic, so treating it as signed is harmless.
  function automatic logic op_a_signed(input mdu_op_t op);
    return !(op inside {OP_MULHU, OP_DIVU, OP_REMU});
  endfunction

  function automatic logic op_b_signed(input mdu_op_t op);
    return op inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
  endfunction

endpackage

// File: rtl/mdu_negate.sv
// Conditional two's-complement: passes the input through, or negates it when neg is high.
module mdu_negate #(
  parameter int W = 32
) (
  input  logic         neg,
  input  logic [W-1:0] in_val,
  output logic [W-1:0] out_val
);

  assign out_val = neg ? ((~in_val) + W'(1)) : in_val;

endmodule

// File: rtl/mdu_iter.sv
// Iterative RV32M multiply/divide: shift-add multiply or restoring divide, one bit per cycle,
// with divide-by-zero and signed-overflow fast paths and a registered result.
module mdu_iter
  import mdu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            flush,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] opA,
  input  logic [XLEN-1:0] opB,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  mdu_state_t state_q, state_d;
  logic [2:0]        op_q, op_d;
  logic [4:0]        cnt_q, cnt_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN:0]     rem_q, rem_d;
  logic [XLEN-1:0]   opnd_q, opnd_d;
  logic              neg_a_q, neg_a_d;
  logic              neg_b_q, neg_b_d;
  logic              fast_q, fast_d;
  logic [XLEN-1:0]   fast_res_q, fast_res_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [XLEN-1:0]   result_q, result_d;

  // Operand conditioning at launch time
  mdu_op_t         op_in;
  logic            in_a_neg, in_b_neg;
  logic [XLEN-1:0] mag_a, mag_b;
  logic            div_zero, div_ovf;

  assign op_in    = mdu_op_t'(funct3);
  assign in_a_neg = op_a_signed(op_in) & opA[XLEN-1];
  assign in_b_neg = op_b_signed(op_in) & opB[XLEN-1];
  assign div_zero = (opB == '0);
  assign div_ovf  = (op_in inside {OP_DIV, OP_REM}) && (opA == OVF_Q) && (opB == '1);

  mdu_negate #(.W(XLEN)) u_neg_a (
    .neg     (in_a_neg),
    .in_val  (opA),
    .out_val (mag_a)
  );

  mdu_negate #(.W(XLEN)) u_neg_b (
    .neg     (in_b_neg),
    .in_val  (opB),
    .out_val (mag_b)
  );

  // Datapath: multiply keeps {hi, multiplier} in acc; divide keeps the quotient/dividend in acc low half
  logic [XLEN:0]   mul_sum;
  logic [XLEN:0]   div_shift;
  logic [XLEN+1:0] div_diff;
  logic            div_fits;

  assign mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
  assign div_shift = {rem_q[XLEN-1:0], acc_q[XLEN-1]};
  assign div_diff  = {1'b0, div_shift} - {2'b00, opnd_q};
  assign div_fits  = ~div_diff[XLEN+1];

  // Divide results are zero-extended into the wide negator; the low half is then the 32-bit negation.
  logic              op_is_mul;
  logic              res_neg;
  logic [2*XLEN-1:0] res_in, res_out;
  logic [XLEN-1:0]   res_sel;

  assign op_is_mul = ~op_q[2];
  assign res_in    = op_is_mul ? acc_q
                               : {{XLEN{1'b0}}, (op_q[1] ? rem_q[XLEN-1:0] : acc_q[XLEN-1:0])};
  assign res_neg   = (op_is_mul || !op_q[1]) ? (neg_a_q ^ neg_b_q) : neg_a_q;

  mdu_negate #(.W(2*XLEN)) u_neg_res (
    .neg     (res_neg),
    .in_val  (res_in),
    .out_val (res_out)
  );

  assign res_sel = (op_is_mul && (op_q != OP_MUL)) ? res_out[2*XLEN-1:XLEN] : res_out[XLEN-1:0];

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    rem_d      = rem_q;
    opnd_d     = opnd_q;
    neg_a_d    = neg_a_q;
    neg_b_d    = neg_b_q;
    fast_d     = fast_q;
    fast_res_d = fast_res_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    result_d   = result_q;

    case (state_q)
      IDLE: begin
        if (start && !flush) begin
          op_d    = funct3;
          neg_a_d = in_a_neg;
          neg_b_d = in_b_neg;
          cnt_d   = '0;
          rem_d   = '0;
          busy_d  = 1'b1;
          fast_d  = 1'b0;
          if (!funct3[2]) begin
            acc_d   = {{XLEN{1'b0}}, mag_b};
            opnd_d  = mag_a;
            state_d = MUL;
          end else begin
            acc_d   = {{XLEN{1'b0}}, mag_a};
            opnd_d  = mag_b;
            state_d = DIV;
            if (div_zero) begin
              fast_d     = 1'b1;
              fast_res_d = funct3[1] ? opA : DIV0_Q;
            end else if (div_ovf) begin
              fast_d     = 1'b1;
              fast_res_d = funct3[1] ? '0 : OVF_Q;
            end
          end
        end
      end

      MUL: begin
        acc_d = {mul_sum, acc_q[XLEN-1:1]};
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) state_d = DONE;
      end

      DIV: begin
        if (fast_q) begin
          state_d = DONE;
        end else begin
          rem_d = div_fits ? div_diff[XLEN:0] : div_shift;
          acc_d = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-2:0], div_fits};
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'd31) state_d = DONE;
        end
      end

      DONE: begin
        done_d   = 1'b1;
        busy_d   = 1'b0;
        result_d = fast_q ? fast_res_q : res_sel;
        state_d  = IDLE;
      end

      default: state_d = IDLE;
    endcase

    // Abort wins over every state action, including the final result write
    if (flush) begin
      state_d  = IDLE;
      busy_d   = 1'b0;
      done_d   = 1'b0;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      op_q       <= '0;
      cnt_q      <= '0;
      acc_q      <= '0;
      rem_q      <= '0;
      opnd_q     <= '0;
      neg_a_q    <= 1'b0;
      neg_b_q    <= 1'b0;
      fast_q     <= 1'b0;
      fast_res_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      result_q   <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      rem_q      <= rem_d;
      opnd_q     <= opnd_d;
      neg_a_q    <= neg_a_d;
      neg_b_q    <= neg_b_d;
      fast_q     <= fast_d;
      fast_res_q <= fast_res_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      result_q   <= result_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_mdu_iter.sv
// Scoreboard bench for mdu_iter: driver queues expected results and due cycles, monitor checks each done.
module tb_mdu_iter;

  logic        clk;
  logic        rst;
  logic        start;
  logic        flush;
  logic [2:0]  funct3;
  logic [31:0] opA;
  logic [31:0] opB;
  logic        busy;
  logic        done;
  logic [31:0] result;

  mdu_iter #(.XLEN(32)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .flush  (flush),
    .funct3 (funct3),
    .opA    (opA),
    .opB    (opB),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [31:0] res;
    int          due;
    string       name;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          fails  = 0;
  int          cyc    = 0;
  logic [31:0] last_result = 32'h0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, req);
    end
  endtask

  // Reference model: plain wide arithmetic and SV division, independent of any bit-serial algorithm
  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ea, eb, p;
    int          sa, sbv;
    if (!f[2]) begin
      ea = (f != 3'b011) ? {{32{a[31]}}, a} : {32'h0, a};
      eb = (f == 3'b000 || f == 3'b001) ? {{32{b[31]}}, b} : {32'h0, b};
      p  = ea * eb;
      return (f == 3'b000) ? p[31:0] : p[63:32];
    end
    if (b == 32'h0) return f[1] ? a : 32'hFFFF_FFFF;
    if (!f[0]) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return f[1] ? 32'h0 : 32'h8000_0000;
      sa  = a;
      sbv = b;
      return f[1] ? 32'(sa % sbv) : 32'(sa / sbv);
    end
    return f[1] ? (a % b) : (a / b);
  endfunction

  function automatic int latency(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (f[2] && (b == 32'h0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) return 2;
    return 33;
  endfunction

  // Monitor: counts edges and checks every done pulse against the scoreboard head
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (done) begin
        if (sb.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL unexpected_done: got result 0x%08h expected no done", result);
        end else begin
          e = sb.pop_front();
          chk({e.name, "_result"}, result, e.res);
          chk({e.name, "_latency"}, 32'(cyc), 32'(e.due));
          chk({e.name, "_busy_at_done"}, {31'h0, busy}, 32'h0);
          $display("txn %s result=0x%08h cycle=%0d", e.name, result, cyc);
          last_result = e.res;
        end
      end
    end
  end

  task automatic wait_empty(input string nm);
    int guard = 0;
    while (sb.size() != 0 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (sb.size() != 0) begin
      checks++;
      fails++;
      $display("FAIL %s_timeout: got %0d pending expected 0 pending", nm, sb.size());
      sb.delete();
    end
    if (guard == 0) @(negedge clk);
  endtask

  task automatic issue_exp(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] expv, input string nm);
    exp_t e;
    wait_empty(nm);
    start  = 1'b1;
    funct3 = f;
    opA    = a;
    opB    = b;
    @(posedge clk);
    #2;
    e.res  = expv;
    e.due  = cyc + latency(f, a, b);
    e.name = nm;
    sb.push_back(e);
    start  = 1'b0;
    funct3 = 3'($urandom);
    opA    = $urandom;
    opB    = $urandom;
    chk({nm, "_busy_after_start"}, {31'h0, busy}, 32'h1);
  endtask

  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input string nm);
    issue_exp(f, a, b, model(f, a, b), nm);
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(9))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    rst    = 1'b1;
    start  = 1'b0;
    flush  = 1'b0;
    funct3 = 3'b000;
    opA    = 32'h0;
    opB    = 32'h0;
    repeat (3) @(posedge clk);
    #2;
    chk("reset_busy", {31'h0, busy}, 32'h0);
    chk("reset_done", {31'h0, done}, 32'h0);
    chk("reset_result", result, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Directed cases with literal expectations
    issue_exp(3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, "mul_7xm3");
    issue_exp(3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, "mulh_min");
    issue_exp(3'b011, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, "mulhu_min");
    issue_exp(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhsu_m1");
    issue_exp(3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, "div_m7_2");
    issue_exp(3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, "rem_m7_2");
    issue_exp(3'b101, 32'd100, 32'd7, 32'd14, "divu_100_7");

    // Start pulses while busy must be ignored
    repeat (5) @(negedge clk);
    start = 1'b1; funct3 = 3'b000; opA = 32'd3; opB = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;

    issue_exp(3'b111, 32'd100, 32'd7, 32'd2, "remu_100_7");
    issue_exp(3'b101, 32'd5, 32'd0, 32'hFFFF_FFFF, "divu_by0");
    issue_exp(3'b110, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, "rem_by0");
    issue_exp(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, "div_ovf");
    issue_exp(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, "rem_ovf");

    // Flush a DIV at T+10, then launch a MUL right away
    issue(3'b100, 32'd1000, 32'd3, "div_flushed");
    repeat (9) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #2;
    flush = 1'b0;
    void'(sb.pop_back());
    chk("flush_busy", {31'h0, busy}, 32'h0);
    chk("flush_done", {31'h0, done}, 32'h0);
    chk("flush_result_held", result, last_result);
    issue(3'b000, 32'd12345, 32'd678, "mul_after_flush");
    wait_empty("mul_after_flush");
    repeat (40) @(negedge clk);
    chk("flush_result_still_held", result, last_result);

    // Reset in the middle of a MUL at T+15
    issue(3'b001, 32'h1234_5678, 32'h9ABC_DEF0, "mulh_reset");
    repeat (14) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #2;
    sb.delete();
    last_result = 32'h0;
    chk("midrst_busy", {31'h0, busy}, 32'h0);
    chk("midrst_done", {31'h0, done}, 32'h0);
    chk("midrst_result", result, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Simultaneous flush and start in IDLE launches nothing
    @(negedge clk);
    start = 1'b1; flush = 1'b1; funct3 = 3'b101; opA = 32'd9; opB = 32'd0;
    @(posedge clk);
    #2;
    start = 1'b0; flush = 1'b0;
    chk("flush_start_busy", {31'h0, busy}, 32'h0);
    repeat (5) @(negedge clk);
    chk("flush_start_busy_later", {31'h0, busy}, 32'h0);

    // Randomized operations against the reference model
    for (int i = 0; i < 40; i++) begin
      logic [2:0]  f;
      logic [31:0] a, b;
      f = 3'($urandom_range(7));
      a = pick_operand();
      b = pick_operand();
      issue(f, a, b, $sformatf("rand%0d_f%0d", i, f));
    end

    wait_empty("final");
    repeat (40) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
